// File: rtl/ram_fifo_ctrl.sv
// Byte FIFO built around an external 128x8 single-port synchronous RAM.
// Prefetch reads win the single port over producer writes; the head entry lives in m_data.
module ram_fifo_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W+1:0] count,
  output logic              full,
  output logic              empty,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              rd_pend;
  logic              rd_issue;

  // Prefetch only when the output register and the read pipe are both free.
  assign rd_issue = !m_valid && !rd_pend && (ram_cnt != '0);

  assign full    = (ram_cnt == (ADDR_W+1)'(DEPTH));
  assign s_ready = !full && !rd_issue && rst_n;
  assign we      = s_valid && s_ready;
  assign addr    = rd_issue ? rd_ptr : wr_ptr;
  assign data_in = s_data;

  assign count = (ADDR_W+2)'(ram_cnt) + (ADDR_W+2)'(rd_pend) + (ADDR_W+2)'(m_valid);
  assign empty = (count == '0);

  // NOTE: reset is sampled on the clock edge, so it sits inside the clocked
  // block rather than in the sensitivity list; all state uses <= to avoid races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end

      // we and rd_issue are mutually exclusive because s_ready masks rd_issue.
      if (we) begin
        ram_cnt <= ram_cnt + (ADDR_W+1)'(1);
      end else if (rd_issue) begin
        ram_cnt <= ram_cnt - (ADDR_W+1)'(1);
      end

      rd_pend <= rd_issue;

      // A pending read only exists while the output register is empty.
      if (rd_pend) begin
        m_data  <= data_out;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural RAM and a queue-based FIFO model.
module tb_ram_fifo_ctrl;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 128;
  localparam int CAP    = 129;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W+1:0] count;
  logic              full;
  logic              empty;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .full(full), .empty(empty),
    .we(we), .addr(addr), .data_in(data_in), .data_out(data_out)
  );

  // Behavioural single-port synchronous RAM: registered read data.
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data_in;
    data_out <= mem[addr];
  end

  int errors = 0;
  int checks = 0;
  int cnt_bad = 0;
  int max_cnt = 0;
  bit full_seen = 0;
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] got[$];
  logic [DATA_W-1:0] sent[$];

  // One clock cycle: sample mid-cycle, update the model, return just after the edge.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
    end else begin
      if (count !== q.size()) cnt_bad++;
      if (empty !== (q.size() == 0)) cnt_bad++;
      if (q.size() == CAP && (full !== 1'b1 || s_ready !== 1'b0)) cnt_bad++;
      if (q.size() < DEPTH && full !== 1'b0) cnt_bad++;
      if (we !== (s_valid && s_ready)) cnt_bad++;
      if (we && data_in !== s_data) cnt_bad++;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (q.size() == CAP) full_seen = 1;
      if (s_valid && s_ready) begin
        q.push_back(s_data);
        sent.push_back(s_data);
      end
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        if (q.size() == 0) cnt_bad++;
        else if (q.pop_front() !== m_data) cnt_bad++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_wait(input logic [DATA_W-1:0] d, output logic [ADDR_W-1:0] a, output bit ok);
    ok = 0;
    a = '0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (s_ready) begin
        a = addr;
        tick();
        ok = 1;
        break;
      end
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic drain(input int n, input int budget);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < budget && got.size() < n; c++) tick();
    m_ready = 1'b0;
    checks++;
    if (got.size() != n) begin
      errors++;
      $display("FAIL drain_timeout: popped %0d, want %0d", got.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b1; s_data = 8'hFF; m_ready = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (we !== 1'b0)      begin errors++; $display("FAIL reset_we: got %b want 0", we); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (count !== '0)     begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0)    begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    rst_n = 1'b1; s_valid = 1'b0;
    cnt_bad = 0;
  endtask

  task automatic test_single_write();
    got.delete(); sent.delete();
    m_ready = 1'b0; s_valid = 1'b1; s_data = 8'hAA;
    #1;
    checks++; if (we !== 1'b1 || addr !== 7'd0 || data_in !== 8'hAA) begin
      errors++; $display("FAIL single_c0: we=%b addr=%0d data_in=%h want we=1 addr=0 data_in=aa", we, addr, data_in);
    end
    tick();
    s_valid = 1'b0;
    #1;
    checks++; if (we !== 1'b0 || addr !== 7'd0 || s_ready !== 1'b0 || count !== 9'd1) begin
      errors++; $display("FAIL single_c1: we=%b addr=%0d s_ready=%b count=%0d want 0/0/0/1", we, addr, s_ready, count);
    end
    tick();
    checks++; if (m_valid !== 1'b0 || count !== 9'd1) begin
      errors++; $display("FAIL single_c2: m_valid=%b count=%0d want 0/1", m_valid, count);
    end
    tick();
    checks++; if (m_valid !== 1'b1 || m_data !== 8'hAA || count !== 9'd1) begin
      errors++; $display("FAIL single_c3: m_valid=%b m_data=%h count=%0d want 1/aa/1", m_valid, m_data, count);
    end
    drain(1, 10);
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a0, a1;
    bit ok0, ok1;
    got.delete(); sent.delete();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    m_ready = 1'b1;
    push_wait(8'hAA, a0, ok0);
    push_wait(8'h55, a1, ok1);
    checks++; if (!ok0 || !ok1 || a0 !== 7'd0 || a1 !== 7'd1) begin
      errors++; $display("FAIL b2b_addr: ok=%0d%0d addr0=%0d addr1=%0d want 1 1 0 1", ok0, ok1, a0, a1);
    end
    drain(2, 20);
    #1;
    checks++; if (got.size() != 2 || got[0] !== 8'hAA || got[1] !== 8'h55) begin
      errors++; $display("FAIL b2b_order: got %p want aa 55", got);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", empty); end
  endtask

  task automatic test_fill_drain();
    int bad = 0;
    got.delete(); sent.delete();
    m_ready = 1'b0;
    for (int c = 0; c < 400; c++) begin
      s_valid = 1'b1;
      s_data  = 8'(sent.size());
      tick();
    end
    s_valid = 1'b0;
    #1;
    checks++; if (sent.size() != CAP) begin errors++; $display("FAIL fill_accepted: got %0d want 129", sent.size()); end
    checks++; if (full !== 1'b1)      begin errors++; $display("FAIL fill_full: got %b want 1", full); end
    checks++; if (count !== 9'd129)   begin errors++; $display("FAIL fill_count: got %0d want 129", count); end
    checks++; if (s_ready !== 1'b0)   begin errors++; $display("FAIL fill_s_ready: got %b want 0", s_ready); end
    drain(CAP, 600);
    for (int i = 0; i < got.size(); i++) if (got[i] !== 8'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL fill_order: %0d values out of order", bad); end
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_empty: got %b want 1", empty); end
  endtask

  task automatic test_mid_reset();
    logic [ADDR_W-1:0] a;
    bit ok;
    got.delete(); sent.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_wait(8'(8'h30 + i), a, ok);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (count !== '0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_state: count=%0d m_valid=%b want 0/0", count, m_valid);
    end
    got.delete(); sent.delete();
    s_valid = 1'b1; s_data = 8'hC3;
    #1;
    checks++; if (we !== 1'b1 || addr !== 7'd0) begin
      errors++; $display("FAIL midrst_addr: we=%b addr=%0d want 1/0", we, addr);
    end
    tick();
    drain(1, 10);
    checks++; if (got.size() != 1 || got[0] !== 8'hC3) begin
      errors++; $display("FAIL midrst_data: got %p want c3", got);
    end
  endtask

  task automatic test_stream();
    int bad = 0;
    got.delete(); sent.delete();
    max_cnt = 0; cnt_bad = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      s_valid = 1'b1;
      s_data  = 8'(sent.size());
      tick();
    end
    drain(sent.size(), 100);
    for (int i = 0; i < got.size(); i++) if (got[i] !== 8'(i)) bad++;
    checks++; if (bad != 0 || got.size() < 15) begin
      errors++; $display("FAIL stream_order: %0d bad of %0d popped", bad, got.size());
    end
    checks++; if (max_cnt > CAP) begin errors++; $display("FAIL stream_max_count: got %0d want <=129", max_cnt); end
    checks++; if (cnt_bad != 0) begin errors++; $display("FAIL stream_model: %0d cycle mismatches, want 0", cnt_bad); end
  endtask

  task automatic test_random();
    int bad = 0;
    got.delete(); sent.delete();
    cnt_bad = 0; full_seen = 0;
    for (int c = 0; c < 1500; c++) begin
      m_ready = (c < 700) ? ($urandom_range(7) == 0) : ($urandom_range(7) != 0);
      s_valid = ($urandom_range(3) != 0);
      s_data  = 8'($urandom);
      tick();
    end
    drain(sent.size(), 600);
    for (int i = 0; i < got.size() && i < sent.size(); i++) if (got[i] !== sent[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL random_order: %0d values differ", bad); end
    checks++; if (!full_seen) begin errors++; $display("FAIL random_full_reached: got 0 want 1"); end
    checks++; if (cnt_bad != 0) begin errors++; $display("FAIL random_model: %0d cycle mismatches, want 0", cnt_bad); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_fill_drain();
    test_mid_reset();
    test_stream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
